// File: rtl/sprite_pkg.sv
// sprite_pkg
// Shared definitions for the sprite engine serial command receiver.
//   CMD_W_DEF / DATA_W_DEF : default command and data field widths
//   frame_t                : one received frame {cmd, data} at default widths
//   rx_state_t             : bit-counter FSM states of the receiver
package sprite_pkg;

    localparam int CMD_W_DEF  = 4;
    localparam int DATA_W_DEF = 10;

    typedef struct packed {
        logic [CMD_W_DEF-1:0]  cmd;
        logic [DATA_W_DEF-1:0] data;
    } frame_t;

    typedef enum logic [1:0] {
        S_CMD,
        S_DATA,
        S_OVER
    } rx_state_t;

endpackage

// File: rtl/spr_cmd_fifo.sv
// spr_cmd_fifo
// First-word-fall-through synchronous FIFO holding received frames.
// A push while full is accepted only if a pop happens in the same cycle,
// in which case the level stays unchanged.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push        : write request, push_data is the entry to store
//   pop         : read request, ignored while empty
//   pop_data    : current head, forced to 0 while empty
//   full, empty : occupancy flags
//   level       : number of entries held (0..DEPTH)
module spr_cmd_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so that full and empty are distinct.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_serial_rx.sv
// sprite_serial_rx
// Serial command receiver for the sprite engine. The host drives a serial
// clock, a commit strobe and a data line, all asynchronous to clk. Each frame
// is CMD_W command bits followed by DATA_W data bits (MSB first) and is
// terminated by a commit. Frames of exactly CMD_W+DATA_W bits are queued in a
// FWFT FIFO and offered over a valid/ready handshake.
// Ports:
//   clk, rst_n                    : system clock, async active-low reset
//   spr_clk, spr_cmd, spr_ser     : host serial interface (asynchronous)
//   out_valid, out_ready          : output handshake
//   out_command, out_data         : FIFO head fields, 0 while empty
//   frame_err                     : one-cycle pulse, malformed frame dropped
//   overflow                      : sticky, valid frame lost to a full FIFO
//   drop_cnt                      : dropped-frame count, saturating at 255
//   fifo_level                    : entries held in the FIFO
//   clr_status                    : clears overflow and drop_cnt
module sprite_serial_rx
    import sprite_pkg::*;
#(
    parameter int CMD_W       = CMD_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          spr_clk,
    input  logic                          spr_cmd,
    input  logic                          spr_ser,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CMD_W-1:0]              out_command,
    output logic [DATA_W-1:0]             out_data,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [7:0]                    drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          clr_status
);

    localparam int TOTAL = CMD_W + DATA_W;
    localparam int NW    = $clog2(TOTAL + 2);

    localparam logic [NW-1:0] N_CMD   = NW'(CMD_W);
    localparam logic [NW-1:0] N_TOTAL = NW'(TOTAL);
    localparam logic [NW-1:0] N_MAX   = NW'(TOTAL + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] cmd_sync;
    logic [SYNC_STAGES-1:0] ser_sync;
    logic                   clk_prev;
    logic                   edge_pulse;
    logic                   cmd_at_edge;
    logic                   ser_at_edge;

    rx_state_t              state;
    logic [NW-1:0]          bit_cnt;
    logic [NW-1:0]          next_cnt;
    rx_state_t              next_state;
    logic [CMD_W-1:0]       cmd_sr;
    logic [DATA_W-1:0]      data_sr;

    logic                   is_commit;
    logic                   is_shift;
    logic                   frame_ok;
    logic                   drop_now;

    logic [TOTAL-1:0]       head;
    logic                   fifo_full;
    logic                   fifo_empty;

    // The spr_clk chain and its history flop reset high so a host holding
    // spr_clk high through reset never looks like a rising edge. The detected
    // edge is registered, and cmd/ser are captured alongside it, so the
    // strobe and data used are the ones sampled together with the first high
    // spr_clk sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync    <= '1;
            cmd_sync    <= '0;
            ser_sync    <= '0;
            clk_prev    <= 1'b1;
            edge_pulse  <= 1'b0;
            cmd_at_edge <= 1'b0;
            ser_at_edge <= 1'b0;
        end else begin
            clk_sync    <= {clk_sync[SYNC_STAGES-2:0], spr_clk};
            cmd_sync    <= {cmd_sync[SYNC_STAGES-2:0], spr_cmd};
            ser_sync    <= {ser_sync[SYNC_STAGES-2:0], spr_ser};
            clk_prev    <= clk_sync[SYNC_STAGES-1];
            edge_pulse  <= clk_sync[SYNC_STAGES-1] & ~clk_prev;
            cmd_at_edge <= cmd_sync[SYNC_STAGES-1];
            ser_at_edge <= ser_sync[SYNC_STAGES-1];
        end
    end

    assign is_commit = edge_pulse & cmd_at_edge;
    assign is_shift  = edge_pulse & ~cmd_at_edge;
    assign frame_ok  = is_commit & (bit_cnt == N_TOTAL);

    // Counter saturates one past a full frame so over-long frames stay
    // distinguishable from exact-length ones however many bits arrive.
    assign next_cnt = (bit_cnt == N_MAX) ? bit_cnt : bit_cnt + 1'b1;

    always_comb begin
        next_state = S_OVER;
        if (next_cnt < N_CMD) begin
            next_state = S_CMD;
        end else if (next_cnt < N_TOTAL) begin
            next_state = S_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_CMD;
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            data_sr   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= is_commit & (bit_cnt != N_TOTAL);
            if (is_commit) begin
                state   <= S_CMD;
                bit_cnt <= '0;
                cmd_sr  <= '0;
                data_sr <= '0;
            end else if (is_shift) begin
                case (state)
                    S_CMD:   cmd_sr  <= CMD_W'({cmd_sr, ser_at_edge});
                    S_DATA:  data_sr <= DATA_W'({data_sr, ser_at_edge});
                    default: ;
                endcase
                bit_cnt <= next_cnt;
                state   <= next_state;
            end
        end
    end

    // A full FIFO still takes the frame if the consumer pops in the same
    // cycle; only a push with nowhere to go counts as a drop.
    assign drop_now = frame_ok & fifo_full & ~out_ready;

    // A drop coinciding with clr_status wins: the count restarts at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop_now) begin
            overflow <= 1'b1;
            if (clr_status) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (clr_status) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    spr_cmd_fifo #(
        .WIDTH (TOTAL),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (frame_ok),
        .push_data ({cmd_sr, data_sr}),
        .pop       (out_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign out_valid   = ~fifo_empty;
    assign out_command = head[TOTAL-1:DATA_W];
    assign out_data    = head[DATA_W-1:0];

endmodule

// File: doc/sprite_serial_rx.md
# sprite_serial_rx

Parametrised serial command receiver for the sprite engine. Samples the host's three-wire interface (`spr_clk`, `spr_cmd`, `spr_ser`) asynchronously. Assembles each frame as a command field followed by a data field, and validates the exact frame length. Valid frames are buffered in a small FIFO and presented to the sprite register file over a valid/ready handshake; status outputs report malformed frames and overflow.

## Interface
Parameters:
- `CMD_W`, 4: command field width, bits, ≥1
- `DATA_W`, 10: data field width, bits, ≥1
- `SYNC_STAGES`, 2: synchroniser depth per input, ≥2
- `FIFO_DEPTH`, 4: output FIFO entries, power of two, ≥2

Ports:
- `clk` in 1: system clock; the only clock
- `rst_n` in 1: reset, asynchronous, active-low
- `spr_clk` in 1: host serial clock, async to `clk`
- `spr_cmd` in 1: host commit strobe, sampled on `spr_clk` rise
- `spr_ser` in 1: host serial data, sampled on `spr_clk` rise
- `out_valid` out 1: FIFO head valid
- `out_ready` in 1: consumer accepts head when high with `out_valid`
- `out_command` out CMD_W: head command
- `out_data` out DATA_W: head data
- `frame_err` out 1: one-cycle pulse, malformed frame discarded
- `overflow` out 1: sticky, valid frame dropped because FIFO full
- `drop_cnt` out 8: dropped-frame count, saturates at 255
- `fifo_level` out clog2(FIFO_DEPTH)+1: entries held
- `clr_status` in 1: clears `overflow` and `drop_cnt`

## Operation
- Each input passes through its own `SYNC_STAGES` flop chain. The `spr_clk` chain and its edge-detect flop reset to 1; the `spr_cmd` and `spr_ser` chains reset to 0. A host holding `spr_clk` high through reset therefore produces no edge.
- Rising edge = synchronised `spr_clk` is 1 and the previous value is 0. All actions below occur only on a detected edge.
- Edge with `spr_cmd`=0 is a shift. The bit counter `n` (0..CMD_W+DATA_W+1, saturating) selects the state:
  - S_CMD, n<CMD_W: `spr_ser` shifts MSB-first into the cmd shift register.
  - S_DATA, CMD_W≤n<CMD_W+DATA_W: shifts MSB-first into the data shift register.
  - S_OVER, n≥CMD_W+DATA_W: bit is discarded and the frame is marked long.
- Edge with `spr_cmd`=1 is a commit; the `spr_ser` value is ignored. If n==CMD_W+DATA_W, the frame is valid and is pushed to the FIFO. Otherwise `frame_err` pulses and nothing is pushed. In all cases n returns to 0 (S_CMD) and both shift registers clear.
- Valid commit with the FIFO full and `out_ready`=0: the frame is dropped, `overflow` sets, and `drop_cnt` increments (saturating).
- Valid commit with the FIFO full and `out_ready`=1 in the same cycle: the push is accepted and the level stays unchanged.
- `clr_status` in the same cycle as a new drop: the new event wins (`overflow`=1, `drop_cnt`=1).
- FIFO is first-word-fall-through. `out_command` and `out_data` show the head while `out_valid`=1; both are 0 when empty.
- Reset mid-frame: partial frame lost, FIFO emptied, counters cleared.

## Timing
- Reset values: `out_valid`, `out_command`, `out_data`, `frame_err`, `overflow`, `drop_cnt`, `fifo_level` all 0; state S_CMD, n=0.
- Edge detect fires SYNC_STAGES+1 clk cycles after the first `clk` edge sampling `spr_clk`=1.
- Push is registered on the detect cycle. `out_valid` rises one cycle later, i.e. SYNC_STAGES+2 cycles after sampling into an empty FIFO.
- `frame_err` pulses on the cycle after detect, for exactly one cycle.
- Host requirements:
  - `spr_clk` high ≥2 and low ≥2 clk periods.
  - `spr_cmd` and `spr_ser` stable from 2 clk periods before to 2 clk periods after each `spr_clk` rise.
- Pop on `out_valid`&`out_ready`; the next head appears the following cycle. Sustained throughput is 1 frame/cycle at the FIFO.

## Structure
- Package `sprite_pkg`:
  - default `CMD_W`/`DATA_W` constants
  - the frame struct {cmd, data}
  - the state enum {S_CMD, S_DATA, S_OVER}
- Sub-module `spr_cmd_fifo`: parametrised FWFT sync FIFO (width CMD_W+DATA_W, depth FIFO_DEPTH), exposing full/empty/level and the simultaneous push/pop-when-full rule.
- Synchronisers stay inline; the top level holds the sync chains, edge detect, bit-counter FSM and status logic.

## Test plan
- Defaults, send bits 1010 1011000011 then commit → `out_valid` after SYNC_STAGES+2 cycles with `out_command`=0xA, `out_data`=0x2C3; pop clears `out_valid`.
- Short frame (13 bits) then commit, and long frame (16 bits) then commit → one `frame_err` pulse each, `fifo_level` stays 0. A following valid frame 0x3/0x155 is received intact.
- `out_ready`=0, send 6 valid frames → `fifo_level`=4, `overflow`=1, `drop_cnt`=2. `clr_status` → both 0, FIFO contents unchanged and popped in order.
- FIFO full, valid commit arrives on the same cycle as a pop → level stays 4 and the new frame is last in order.
- Assert `rst_n` low after 7 bits, release, send full frame 0x5/0x0F0 → only 0x5/0x0F0 is output. `spr_clk` held high across reset produces no shift.
- 300 drops with `out_ready`=0 → `drop_cnt`=255 (saturated).
